// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one instruction at a time, either ALU passthrough
// or a single memory access with lane alignment, ending in at most one RF write.
module lsu_wb #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_sdata,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  done,
  output logic                  misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]            state;
  logic                  is_load;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [XLEN-1:0]       result_q;
  logic                  done_q;
  logic                  mis_q;

  // Access width from funct3[1:0]; the undefined codes fall into word width.
  logic            sz_byte, sz_half, in_mis;
  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_wdata;

  always_comb begin
    sz_byte = (in_funct3[1:0] == 2'b00);
    sz_half = (in_funct3[1:0] == 2'b01);
    in_mis  = sz_half ? in_addr[0] : (sz_byte ? 1'b0 : (in_addr[1:0] != 2'b00));
    if (sz_byte) begin
      st_mask  = 4'b0001 << in_addr[1:0];
      st_wdata = {4{in_sdata[7:0]}};
    end else if (sz_half) begin
      st_mask  = 4'b0011 << in_addr[1:0];
      st_wdata = {2{in_sdata[15:0]}};
    end else begin
      st_mask  = 4'b1111;
      st_wdata = in_sdata;
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   ld_data = {{(XLEN-8){ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN-16){ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      is_load   <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          f3_q    <= in_funct3;
          off_q   <= in_addr[1:0];
          rd_q    <= in_rd;
          is_load <= (in_op == 2'd1);
          we_q    <= (in_op == 2'd2);
          case (in_op)
            2'd0: begin
              result_q <= in_addr;
              state    <= S_WB;
            end
            2'd3: done_q <= 1'b1;
            default: begin
              if (in_mis) begin
                // Dropped access: report and retire without touching memory.
                mis_q  <= 1'b1;
                done_q <= 1'b1;
              end else begin
                mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_wmask <= st_mask;
                state     <= S_REQ;
              end
            end
          endcase
        end
        S_REQ: if (mem_req_ready) state <= S_WAIT;
        S_WAIT: if (mem_rsp_valid) begin
          if (is_load) begin
            result_q <= ld_data;
            state    <= S_WB;
          end else begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign mem_we        = (state == S_REQ) & we_q;
  assign rf_wen        = (state == S_WB) & (rd_q != '0);
  assign rf_waddr      = (state == S_WB) ? rd_q : '0;
  assign rf_wdata      = (state == S_WB) ? result_q : '0;
  assign done          = done_q | (state == S_WB);
  assign misalign      = mis_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: directed scenarios plus randomized ops
// checked against a byte-level reference of the load/store rules.
module tb_lsu_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_sdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done, misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_wb #(.XLEN(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .misalign(misalign)
  );

  function automatic int width_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Assemble the addressed bytes little-endian, then sign-adjust signed narrow loads.
  function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    int w;
    longint v;
    logic [7:0] b[4];
    w = width_of(f3);
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    v = 0;
    for (int i = w - 1; i >= 0; i--) v = v * 256 + longint'(b[int'(off) + i]);
    if (!f3[2] && w < 4 && b[int'(off) + w - 1][7]) v = v - (longint'(1) << (8 * w));
    return v[31:0];
  endfunction

  // Issue one instruction and follow it to retirement, checking every cycle.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rdy_dly, input int rsp_dly);
    int w;
    logic mis;
    logic [3:0] emask;
    logic [31:0] ewdata, exp;
    w = width_of(f3);
    mis = (op == 2'd1 || op == 2'd2) && ((addr % w) != 0);
    emask = (w == 1) ? 4'b0001 : (w == 2) ? 4'b0011 : 4'b1111;
    emask = emask << addr[1:0];
    ewdata = (w == 1) ? {4{sdata[7:0]}} : (w == 2) ? {2{sdata[15:0]}} : sdata;

    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%0b exp=1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_addr = addr; in_sdata = sdata; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_sdata = $urandom; in_rd = 5'($urandom);

    if (op == 2'd0 || op == 2'd3 || mis) begin
      checks++;
      if ({done, misalign, rf_wen, mem_req_valid} !== {1'b1, mis, (op == 2'd0) && (rd != 0), 1'b0}) begin
        failures++;
        $display("FAIL short_retire op=%0d got done/mis/wen/req=%b exp=%b", op,
                 {done, misalign, rf_wen, mem_req_valid}, {1'b1, mis, (op == 2'd0) && (rd != 0), 1'b0});
      end
      checks++;
      if (op == 2'd0 && {rf_waddr, rf_wdata} !== {rd, addr}) begin
        failures++; $display("FAIL alu_wb got=%0d/%h exp=%0d/%h", rf_waddr, rf_wdata, rd, addr);
      end
      @(negedge clk);
      checks++;
      if ({done, misalign, rf_wen} !== 3'b000) begin
        failures++; $display("FAIL short_pulse got=%b exp=000", {done, misalign, rf_wen});
      end
      return;
    end

    for (int k = 0; k <= rdy_dly; k++) begin
      mem_req_ready = (k == rdy_dly);
      checks++;
      if ({mem_req_valid, mem_we, in_ready, done, rf_wen} !== {1'b1, op == 2'd2, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL req_ctrl cyc=%0d got=%b exp=%b", k,
                 {mem_req_valid, mem_we, in_ready, done, rf_wen}, {1'b1, op == 2'd2, 3'b000});
      end
      checks++;
      if (mem_addr !== {addr[31:2], 2'b00} || mem_wmask !== emask) begin
        failures++;
        $display("FAIL req_addr got=%h/%b exp=%h/%b", mem_addr, mem_wmask, {addr[31:2], 2'b00}, emask);
      end
      if (op == 2'd2) begin
        checks++;
        if (mem_wdata !== ewdata) begin
          failures++; $display("FAIL req_wdata got=%h exp=%h", mem_wdata, ewdata);
        end
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;

    for (int k = 0; k <= rsp_dly; k++) begin
      checks++;
      if ({mem_req_valid, done, rf_wen, in_ready} !== 4'b0000) begin
        failures++; $display("FAIL wait_state got=%b exp=0000", {mem_req_valid, done, rf_wen, in_ready});
      end
      if (k == rsp_dly) begin
        mem_rsp_valid = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0; mem_rdata = $urandom;

    if (op == 2'd1) begin
      exp = load_ref(rdata, f3, addr[1:0]);
      checks++;
      if ({done, rf_wen, misalign} !== {1'b1, rd != 0, 1'b0}) begin
        failures++; $display("FAIL load_ctrl got=%b exp=%b", {done, rf_wen, misalign}, {1'b1, rd != 0, 1'b0});
      end
      checks++;
      if (rf_wdata !== exp || rf_waddr !== rd) begin
        failures++;
        $display("FAIL load_data f3=%0d addr=%h got=%0d/%h exp=%0d/%h", f3, addr, rf_waddr, rf_wdata, rd, exp);
      end
    end else begin
      checks++;
      if ({done, rf_wen, misalign} !== 3'b100) begin
        failures++; $display("FAIL store_ack got=%b exp=100", {done, rf_wen, misalign});
      end
    end
    @(negedge clk);
    checks++;
    if ({done, rf_wen, in_ready} !== 3'b001) begin
      failures++; $display("FAIL retire_idle got=%b exp=001", {done, rf_wen, in_ready});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, mem_req_valid, mem_we, rf_wen, done, misalign, mem_addr, mem_wdata, mem_wmask,
         rf_waddr, rf_wdata} !== {1'b1, 5'b0, 32'h0, 32'h0, 4'h0, 5'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_vals rdy=%b req=%b we=%b wen=%b done=%b mis=%b addr=%h wd=%h mask=%b wa=%0d rd=%h",
               in_ready, mem_req_valid, mem_we, rf_wen, done, misalign, mem_addr, mem_wdata,
               mem_wmask, rf_waddr, rf_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    run_op(2'd0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0, 0);
    run_op(2'd0, 3'd2, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'h0, 0, 0);
    run_op(2'd3, 3'd0, 32'h0000_0004, 32'h0, 5'd7, 32'h0, 0, 0);
  endtask

  task automatic test_load;
    run_op(2'd1, 3'b000, 32'h8000_0003, 32'h0, 5'd9, 32'h80FF_7F01, 0, 0);
    run_op(2'd1, 3'b100, 32'h8000_0003, 32'h0, 5'd9, 32'h80FF_7F01, 0, 0);
    run_op(2'd1, 3'b001, 32'h8000_0002, 32'h0, 5'd3, 32'h80FF_7F01, 1, 2);
    run_op(2'd1, 3'b101, 32'h8000_0000, 32'h0, 5'd3, 32'h80FF_FF01, 0, 1);
    run_op(2'd1, 3'b010, 32'h8000_0004, 32'h0, 5'd31, 32'hCAFE_F00D, 0, 0);
    run_op(2'd1, 3'b010, 32'h8000_0008, 32'h0, 5'd0, 32'hCAFE_F00D, 0, 0);
  endtask

  task automatic test_store;
    run_op(2'd2, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 5'd4, 32'h0, 0, 0);
    run_op(2'd2, 3'b000, 32'h8000_0001, 32'h1234_56A5, 5'd4, 32'h0, 0, 1);
    run_op(2'd2, 3'b010, 32'h8000_0010, 32'h0102_0304, 5'd4, 32'h0, 0, 0);
    run_op(2'd2, 3'b111, 32'h8000_0014, 32'h5566_7788, 5'd4, 32'h0, 0, 0);
  endtask

  task automatic test_stall;
    run_op(2'd2, 3'b010, 32'h4000_0020, 32'h1357_9BDF, 5'd1, 32'h0, 4, 0);
    run_op(2'd1, 3'b000, 32'h4000_0021, 32'h0, 5'd2, 32'h0000_7F00, 4, 3);
  endtask

  task automatic test_misalign;
    run_op(2'd1, 3'b010, 32'h8000_0002, 32'h0, 5'd6, 32'h0, 0, 0);
    run_op(2'd1, 3'b001, 32'h8000_0003, 32'h0, 5'd6, 32'h0, 0, 0);
    run_op(2'd2, 3'b010, 32'h8000_0001, 32'hFFFF_FFFF, 5'd6, 32'h0, 0, 0);
    run_op(2'd2, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 5'd6, 32'h0, 0, 0);
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_funct3 = 3'b010; in_addr = 32'h8000_0040; in_rd = 5'd12;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, mem_req_valid, mem_we, rf_wen, done, misalign, mem_addr, mem_wdata, mem_wmask,
         rf_waddr, rf_wdata} !== {1'b1, 5'b0, 32'h0, 32'h0, 4'h0, 5'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_in_wait rdy=%b req=%b wen=%b done=%b addr=%h", in_ready, mem_req_valid,
               rf_wen, done, mem_addr);
    end
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({in_ready, mem_req_valid, rf_wen, done, misalign} !== 5'b10000) begin
        failures++;
        $display("FAIL stale_rsp cyc=%0d got=%b exp=10000", k, {in_ready, mem_req_valid, rf_wen, done, misalign});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [2:0] f3;
    logic [1:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      if (op == 2'd2) f3 = {1'b0, f3[1:0]};
      run_op(op, f3, $urandom, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_funct3 = '0; in_addr = '0; in_sdata = '0; in_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_stall;
    test_misalign;
    test_reset_wait;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store plus writeback stage, directly upstream of the register file write port (rf_wen/rf_waddr/rf_wdata).
- Accepts one retiring instruction from EXU at a time and either passes an ALU result through or performs a memory access.
- Drives a simple valid/ready memory request channel and a response channel; byte-lane alignment and sign extension are done here.
- Produces exactly one register write (loads, ALU ops) or none (stores) per accepted instruction.

Parameters:
- XLEN, 32, data/address width; fixed to 32 for this core.
- ADDR_WIDTH, 5, register index width; matches register file.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EXU offers an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- in_op  in  2  0=ALU writeback, 1=load, 2=store, 3=no-writeback (nop)
- in_funct3  in  3  RV32 load/store width code
- in_addr  in  XLEN  effective address, or ALU result for op 0
- in_sdata  in  XLEN  store data (rs2)
- in_rd  in  ADDR_WIDTH  destination register
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1=write
- mem_addr  out  XLEN  word-aligned address (in_addr with low 2 bits zeroed)
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  4  byte-enable
- mem_rsp_valid  in  1  response/ack valid (one cycle)
- mem_rdata  in  XLEN  read word
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  XLEN  register file write data
- done  out  1  one-cycle pulse per retired instruction
- misalign  out  1  one-cycle pulse, misaligned access dropped

Behaviour:
- Reset: state IDLE; in_ready=1; mem_req_valid, mem_we, rf_wen, done, misalign=0; mem_addr, mem_wdata, mem_wmask, rf_waddr, rf_wdata=0. Any in-flight access is abandoned; a mem_rsp_valid arriving after reset while in IDLE is ignored.
- States: IDLE, REQ, WAIT, WB.
- IDLE: accept when in_valid (in_ready=1); latch op, funct3, addr, sdata, rd.
  - op 0: go WB with result=in_addr.
  - op 3: next cycle done=1, no write, stay IDLE.
  - op 1/2 aligned: go REQ.
  - op 1/2 misaligned (halfword addr[0]=1; word addr[1:0]!=0): next cycle misalign=1, done=1, no memory access, no write.
- REQ: mem_req_valid=1, address/data/mask stable until mem_req_ready; handshake cycle -> WAIT; mem_req_valid drops the cycle after.
- WAIT: on mem_rsp_valid: load -> capture formatted data, go WB; store -> done=1 next cycle, go IDLE. A response coincident with the REQ handshake cycle is not legal; memory returns it at least one cycle later.
- WB: one cycle rf_wen=1 (forced 0 when rd=0), rf_waddr=rd, rf_wdata=result, done=1; -> IDLE.
- Latency from accept: ALU op = 1 cycle (write in the cycle after accept); load = 3 cycles minimum (ready same cycle, response next).
- Store lanes (off = addr[1:0]):
  - SB(000): mask = 0001<<off; wdata = sdata[7:0] replicated to all 4 bytes.
  - SH(001): mask = 0011<<off; wdata = sdata[15:0] replicated.
  - SW(010): mask = 1111; wdata = sdata.
- Load select: LB(000)/LBU(100) take byte off; LH(001)/LHU(101) take halfword off[1]. Signed codes sign-extend; unsigned codes zero-extend. LW(010) takes the full word.
- Undefined funct3 (011, 110, 111): treat as LW/SW width.
- rf outputs are 0 in every non-WB cycle; done and misalign are never asserted more than one cycle.

Test Plan:
- ALU op, in_addr=0x1234_5678, rd=5 -> cycle after accept: rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, done=1.
- LB at addr 0x8000_0003; mem_rdata=0x80FF_7F01 -> rf_wdata=0xFFFF_FF80. Same access as LBU -> 0x0000_0080; mem_addr=0x8000_0000.
- SH at addr 0x8000_0002, sdata=0xAAAA_BEEF -> mem_we=1, mem_wmask=1100, mem_wdata=0xBEEF_BEEF. After ack: done=1, rf_wen=0.
- mem_req_ready held low 4 cycles -> mem_req_valid stays 1 with stable addr/data; in_ready=0 throughout.
- LW at addr 0x8000_0002 -> misalign=1 and done=1 next cycle, no mem_req_valid, no rf_wen. Load to rd=0 -> done=1, rf_wen=0.
- Assert rst during WAIT, then pulse mem_rsp_valid -> outputs stay at reset values, in_ready=1, no rf_wen.
